exc_controller: RTL

Exception request controller that sits directly upstream of the exception unit. It collects the pipeline's exception sources (invalid opcode from decode, data abort from memory, external interrupt), latches them as pending, and prioritises them. It drives the single `Exc` request line and the 4-bit `EStatus` code, then tracks the handshake through `ExcAck` (fetch reached the vector) and `ERet` (handler returned). It enforces one exception in service at a time and flags a stalled acknowledge.

---
 rtl/exc_controller.sv | 121 ++++++++++++
 1 files changed

// File: rtl/exc_controller.sv
// Exception request controller: latches opcode/abort/IRQ causes, prioritises them, drives Exc/EStatus and tracks ExcAck/ERet.
// Optional external interrupt path is built only when EXC_IRQ_EN is defined.
module exc_controller #(
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       BadOpcode_D,
   input  logic       DataAbort_M,
   input  logic       ExtIRQ,
   input  logic       IRQEnable,
   input  logic       ExcAck,
   input  logic       ERet,
   output logic       Exc,
   output logic [3:0] EStatus,
   output logic       ExcBusy,
   output logic       AckTimeout
);
   localparam int              CW      = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0]   CNT_MAX = CW'(TIMEOUT_CYCLES);
   localparam logic [3:0]      C_NONE  = 4'b0000;
   localparam logic [3:0]      C_OP    = 4'b0010;
   localparam logic [3:0]      C_AB    = 4'b0100;
   localparam logic [3:0]      C_IRQ   = 4'b0001;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_HANDLER} state_t;

   state_t        state_q;
   logic          exc_q, busy_q, tmo_q;
   logic [3:0]    estatus_q, cause_d;
   logic          pend_op_q, pend_op_d, pend_ab_q, pend_ab_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          irq_req, ack_edge;

`ifdef EXC_IRQ_EN
   logic [SYNC_STAGES-1:0] irq_sync_q;

   always_ff @(posedge clk) begin
      if (!reset) irq_sync_q <= '0;
      else        irq_sync_q <= {irq_sync_q[SYNC_STAGES-2:0], ExtIRQ};
   end

   assign irq_req = irq_sync_q[SYNC_STAGES-1] & IRQEnable;
`else
   logic unused_irq;
   assign unused_irq = ExtIRQ ^ IRQEnable;
   assign irq_req    = 1'b0;
`endif

   assign ack_edge = (state_q == S_REQ) && ExcAck;

   always_comb begin
      cause_d = C_NONE;
      if (pend_op_q)      cause_d = C_OP;
      else if (pend_ab_q) cause_d = C_AB;
      else if (irq_req)   cause_d = C_IRQ;

      // Clear the serviced cause first so a same-edge pulse re-arms it.
      pend_op_d = pend_op_q;
      pend_ab_d = pend_ab_q;
      if (ack_edge && estatus_q == C_OP) pend_op_d = 1'b0;
      if (ack_edge && estatus_q == C_AB) pend_ab_d = 1'b0;
      if (BadOpcode_D) pend_op_d = 1'b1;
      if (DataAbort_M) pend_ab_d = 1'b1;

      cnt_d = cnt_q;
      if (state_q == S_IDLE)                          cnt_d = '0;
      else if (state_q == S_REQ && cnt_q != CNT_MAX)  cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         exc_q     <= 1'b0;
         busy_q    <= 1'b0;
         tmo_q     <= 1'b0;
         estatus_q <= C_NONE;
         pend_op_q <= 1'b0;
         pend_ab_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         pend_op_q <= pend_op_d;
         pend_ab_q <= pend_ab_d;
         cnt_q     <= cnt_d;
         if (state_q == S_REQ && !ExcAck && cnt_d == CNT_MAX) tmo_q <= 1'b1;
         case (state_q)
            S_IDLE: begin
               if (pend_op_q || pend_ab_q || irq_req) begin
                  state_q   <= S_REQ;
                  exc_q     <= 1'b1;
                  busy_q    <= 1'b1;
                  estatus_q <= cause_d;
               end
            end
            S_REQ: begin
               if (ExcAck) begin
                  state_q <= S_HANDLER;
                  exc_q   <= 1'b0;
               end
            end
            S_HANDLER: begin
               if (ERet) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= S_IDLE;
               exc_q   <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign Exc        = exc_q;
   assign EStatus    = estatus_q;
   assign ExcBusy    = busy_q;
   assign AckTimeout = tmo_q;
endmodule
